// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
//   XLEN / ADDR_W / DATA_W : 32-bit address and instruction widths
//   NOP                    : instruction returned on a faulting fetch
//   imem_state_e           : responder FSM states
package imem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } imem_state_e;
endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH_WORDS x 32, synchronous write and synchronous read.
//   clk_i, rst_i          : clock; reset clears only the read-data register
//   we_i/waddr_i/wdata_i  : word write port
//   re_i/raddr_i          : read strobe and word index
//   rdata_o               : registered read data, held while re_i is low
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Contents are never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Nonblocking read of mem_q sees the pre-write value on a same-edge write.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= NOP;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one PC request at a time, returns the
// stored word LATENCY cycles later and holds it until the consumer takes it.
//   clk_i, rst_i                          : clock, sync active-high reset
//   req_valid_i, req_addr_i, req_ready_o  : fetch request handshake
//   pc_write_o                            : PC update enable (== req_ready_o)
//   resp_valid_o, resp_ready_i            : response handshake
//   resp_instr_o, resp_addr_o, resp_err_o : response payload
//   flush_i                               : redirect, cancels in-flight fetch
//   load_en_i, load_addr_i, load_data_i   : storage preload port
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              pc_write_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_instr_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic              resp_err_o,
  input  logic              flush_i,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i
);
  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  // BUSY lasts LATENCY-1 cycles; counter runs down to zero then hands to RESP.
  localparam logic [3:0]  BUSY_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  imem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              accept;
  logic              req_fault;
  logic              load_ok;
  logic [DATA_W-1:0] rdata;
  logic              unused_load_lsb;

  assign req_fault = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:2] >= DEPTH_LIM);
  assign load_ok   = load_en_i && !rst_i && (load_addr_i[31:2] < DEPTH_LIM);
  assign unused_load_lsb = ^load_addr_i[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    err_d       = err_q;
    req_ready_o = 1'b0;

    unique case (state_q)
      IDLE:    req_ready_o = ~flush_i;
      BUSY:    req_ready_o = 1'b0;
      RESP:    req_ready_o = resp_ready_i & ~flush_i;
      default: req_ready_o = 1'b0;
    endcase
    accept = req_valid_i & req_ready_o;

    unique case (state_q)
      IDLE: ;
      BUSY: begin
        if (flush_i)           state_d = IDLE;
        else if (cnt_q == 4'd0) state_d = RESP;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (flush_i || resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush already blocks req_ready_o, so acceptance never races a flush.
    if (accept) begin
      addr_d = req_addr_i;
      err_d  = req_fault;
      if (LATENCY == 1) begin
        state_d = RESP;
      end else begin
        state_d = BUSY;
        cnt_d   = BUSY_INIT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Read only on a clean acceptance; the read register then holds the word
  // for the whole fetch, so later loads cannot disturb it.
  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (load_ok),
    .waddr_i(load_addr_i[IDX_W+1:2]),
    .wdata_i(load_data_i),
    .re_i   (accept && !req_fault && !rst_i),
    .raddr_i(req_addr_i[IDX_W+1:2]),
    .rdata_o(rdata)
  );

  assign pc_write_o   = req_ready_o;
  assign resp_valid_o = (state_q == RESP);
  assign resp_addr_o  = addr_q;
  assign resp_err_o   = err_q;
  assign resp_instr_o = err_q ? NOP : rdata;
endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
  localparam int DEPTH = 64;
  localparam int LAT_A = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, resp_ready, flush, load_en;
  logic [31:0] req_addr, load_addr, load_data;
  logic        req_ready, pc_write, resp_valid, resp_err;
  logic [31:0] resp_instr, resp_addr;

  logic        req_valid_b, resp_ready_b, flush_b, load_en_b;
  logic [31:0] req_addr_b, load_addr_b, load_data_b;
  logic        req_ready_b, pc_write_b, resp_valid_b, resp_err_b;
  logic [31:0] resp_instr_b, resp_addr_b;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_ready_o(req_ready), .pc_write_o(pc_write), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .resp_instr_o(resp_instr), .resp_addr_o(resp_addr),
    .resp_err_o(resp_err), .flush_i(flush), .load_en_i(load_en),
    .load_addr_i(load_addr), .load_data_i(load_data));

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_b), .req_addr_i(req_addr_b),
    .req_ready_o(req_ready_b), .pc_write_o(pc_write_b), .resp_valid_o(resp_valid_b),
    .resp_ready_i(resp_ready_b), .resp_instr_o(resp_instr_b), .resp_addr_o(resp_addr_b),
    .resp_err_o(resp_err_b), .flush_i(flush_b), .load_en_i(load_en_b),
    .load_addr_i(load_addr_b), .load_data_i(load_data_b));

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_mem [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [31:0] pre(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic logic fault(logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_addr = 0; resp_ready = 1; flush = 0;
    load_en = 0; load_addr = 0; load_data = 0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); load_en = 1; load_addr = a; load_data = d;
    @(negedge clk); load_en = 0;
    if (a[31:2] < 30'(DEPTH)) mdl_mem[int'(a[31:2])] = d;
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] a,
                          input logic [31:0] ei, input logic ee);
    @(negedge clk); req_valid = 1; req_addr = a; resp_ready = 1; #1;
    chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk); req_valid = 0; #1;
    for (int k = 1; k < LAT_A; k++) begin
      chk({nm, "_early_valid"}, {31'd0, resp_valid}, 32'd0);
      @(negedge clk); #1;
    end
    chk({nm, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({nm, "_instr"}, resp_instr, ei);
    chk({nm, "_addr"}, resp_addr, a);
    chk({nm, "_err"}, {31'd0, resp_err}, {31'd0, ee});
    @(negedge clk); #1;
    chk({nm, "_drop"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  // Reference model state for the random phase: one outstanding fetch,
  // visible once its age (edges since acceptance) reaches LAT_A.
  logic        m_has;
  int          m_age;
  logic [31:0] m_instr, m_addr;
  logic        m_err;

  initial begin
    logic [31:0] saved;
    logic        exp_valid, exp_ready;
    int          seen;

    rst = 1; idle_inputs();
    req_valid_b = 0; req_addr_b = 0; resp_ready_b = 1; flush_b = 0;
    load_en_b = 0; load_addr_b = 0; load_data_b = 0;
    repeat (2) @(negedge clk);
    rst = 0; #1;
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_err",   {31'd0, resp_err}, 32'd0);
    chk("rst_instr", resp_instr, 32'd0);
    chk("rst_addr",  resp_addr, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_pcw",   {31'd0, pc_write}, 32'd1);
    chk("rst_b_valid", {31'd0, resp_valid_b}, 32'd0);

    for (int i = 0; i < DEPTH; i++) load_word(32'(i * 4), pre(i));
    load_word(32'h10, 32'h2002_0005);
    load_word(32'(4 * DEPTH), 32'hBAD0_BAD0);  // out of range, must be ignored

    vecs[0] = '{32'h0000_0010, 32'h2002_0005, 1'b0};
    vecs[1] = '{32'h0000_0012, 32'h0, 1'b1};
    vecs[2] = '{32'(4 * DEPTH), 32'h0, 1'b1};
    vecs[3] = '{32'h0000_0000, pre(0), 1'b0};
    vecs[4] = '{32'(4 * (DEPTH - 1)), pre(DEPTH - 1), 1'b0};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0, 1'b1};
    vecs[6] = '{32'h0000_0101, 32'h0, 1'b1};
    vecs[7] = '{32'h0000_0020, pre(8), 1'b0};
    for (int v = 0; v < 8; v++)
      do_fetch($sformatf("vec%0d", v), vecs[v].addr, vecs[v].instr, vecs[v].err);

    // Consumer stall with a competing request and a load to the fetched word.
    @(negedge clk); req_valid = 1; req_addr = 32'h10; resp_ready = 0;
    @(negedge clk); req_valid = 0;
    @(negedge clk); #1;
    chk("stall_valid0", {31'd0, resp_valid}, 32'd1);
    saved = mdl_mem[4];
    req_valid = 1; req_addr = 32'h40;
    load_en = 1; load_addr = 32'h10; load_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); load_en = 0; #1;
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_instr", resp_instr, saved);
      chk("stall_addr",  resp_addr, 32'h10);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_pcw",   {31'd0, pc_write}, 32'd0);
    end
    mdl_mem[4] = 32'hDEAD_BEEF;
    req_valid = 0; resp_ready = 1;
    @(negedge clk); #1;
    chk("stall_release", {31'd0, resp_valid}, 32'd0);
    do_fetch("after_load", 32'h10, 32'hDEAD_BEEF, 1'b0);

    // Load to the same word on the accepting edge returns the old data.
    saved = mdl_mem[12];
    @(negedge clk); req_valid = 1; req_addr = 32'h30; resp_ready = 1;
    load_en = 1; load_addr = 32'h30; load_data = 32'h1234_5678;
    @(negedge clk); req_valid = 0; load_en = 0;
    mdl_mem[12] = 32'h1234_5678;
    @(negedge clk); #1;
    chk("rbw_valid", {31'd0, resp_valid}, 32'd1);
    chk("rbw_instr", resp_instr, saved);
    do_fetch("rbw_new", 32'h30, 32'h1234_5678, 1'b0);

    // Flush one cycle after acceptance; only the follow-up fetch responds.
    @(negedge clk); req_valid = 1; req_addr = 32'h20; resp_ready = 1;
    @(negedge clk); req_valid = 0; flush = 1; #1;
    chk("flush_busy_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); flush = 0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      #1; if (resp_valid) seen++;
      @(negedge clk);
    end
    req_valid = 1; req_addr = 32'h24; #1;
    chk("flush_next_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); req_valid = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (resp_valid) begin
        seen++;
        chk("flush_next_addr", resp_addr, 32'h24);
        chk("flush_next_instr", resp_instr, mdl_mem[9]);
      end
      @(negedge clk);
    end
    chk("flush_resp_count", 32'(seen), 32'd1);

    // Reset while BUSY drops the fetch; storage survives.
    @(negedge clk); req_valid = 1; req_addr = 32'h10; resp_ready = 1;
    @(negedge clk); req_valid = 0; rst = 1;
    @(negedge clk); rst = 0; #1;
    chk("rstbusy_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstbusy_ready", {31'd0, req_ready}, 32'd1);
    chk("rstbusy_pcw",   {31'd0, pc_write}, 32'd1);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1; if (resp_valid) seen++;
    end
    chk("rstbusy_no_resp", 32'(seen), 32'd0);
    do_fetch("rstbusy_reread", 32'h10, mdl_mem[4], 1'b0);

    // LATENCY=1 instance: back-to-back fetches, one response per cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); load_en_b = 1; load_addr_b = 32'(i * 4); load_data_b = 32'hB000_0000 + 32'(i);
    end
    @(negedge clk); load_en_b = 0;
    req_valid_b = 1; req_addr_b = 32'h0; resp_ready_b = 1; #1;
    chk("b2b_idle_valid", {31'd0, resp_valid_b}, 32'd0);
    chk("b2b_ready0", {31'd0, req_ready_b}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) req_addr_b = 32'((i + 1) * 4); else req_valid_b = 0;
      #1;
      chk($sformatf("b2b_valid%0d", i), {31'd0, resp_valid_b}, 32'd1);
      chk($sformatf("b2b_instr%0d", i), resp_instr_b, 32'hB000_0000 + 32'(i));
      chk($sformatf("b2b_addr%0d", i), resp_addr_b, 32'(i * 4));
      if (i < 2) chk($sformatf("b2b_ready%0d", i), {31'd0, req_ready_b}, 32'd1);
    end
    @(negedge clk); #1;
    chk("b2b_end_valid", {31'd0, resp_valid_b}, 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    m_has = 0; m_age = 0; m_instr = 0; m_addr = 0; m_err = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 99) < 2);
      req_valid  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0:       req_addr = $urandom();
        1:       req_addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        default: req_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      resp_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 9) == 0);
      load_en    = ($urandom_range(0, 9) < 2);
      case ($urandom_range(0, 4))
        0:       load_addr = {req_addr[31:2], 2'b00};
        1:       load_addr = $urandom() | 32'h8000_0000;
        default: load_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      load_data = $urandom();
      #1;
      exp_valid = m_has && (m_age >= LAT_A);
      exp_ready = !flush && (!m_has || (exp_valid && resp_ready));
      chk("rnd_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("rnd_pcw",   {31'd0, pc_write}, {31'd0, exp_ready});
      chk("rnd_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        chk("rnd_instr", resp_instr, m_instr);
        chk("rnd_addr",  resp_addr, m_addr);
        chk("rnd_err",   {31'd0, resp_err}, {31'd0, m_err});
      end
      if (rst) begin
        m_has = 0;
      end else begin
        if (req_valid && exp_ready) begin
          m_has = 1; m_age = 1; m_addr = req_addr; m_err = fault(req_addr);
          m_instr = m_err ? 32'h0 : mdl_mem[int'(req_addr[31:2])];
        end else if (flush) begin
          m_has = 0;
        end else if (m_has) begin
          if (exp_valid && resp_ready) m_has = 0;
          else if (m_age < LAT_A) m_age++;
        end
        if (load_en && !fault({load_addr[31:2], 2'b00}))
          mdl_mem[int'(load_addr[31:2])] = load_data;
      end
    end
    @(negedge clk); rst = 0; idle_inputs();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
